// File: rtl/branch_resolver.sv
// In-order branch resolution queue: matches EX outcomes against IF predictions.
// Optional BR_RESOLVER_STATS_EN adds saturating branch/mispredict counters.
module branch_resolver #(
  parameter int DEPTH      = 4,
  parameter int INDEX_BITS = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pred_valid,
  input  logic [31:0]              pred_pc,
  input  logic                     pred_taken,
  input  logic [31:0]              pred_target,
  output logic                     pred_ready,
  input  logic                     res_valid,
  input  logic                     res_taken,
  input  logic [31:0]              res_target,
  input  logic                     flush,
  output logic                     update_en,
  output logic [31:0]              update_pc,
  output logic                     actual_taken,
  output logic                     mispredict,
  output logic [31:0]              redirect_pc,
  output logic [$clog2(DEPTH):0]   count
`ifdef BR_RESOLVER_STATS_EN
  ,
  output logic [31:0]              stat_branches,
  output logic [31:0]              stat_mispredicts
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("branch_resolver: DEPTH must be a power of 2, >= 2");
  end
  if (INDEX_BITS < 1 || INDEX_BITS > 30) begin : g_bad_index
    $error("branch_resolver: INDEX_BITS out of range");
  end

  logic [31:0]   pc_q  [DEPTH];
  logic          tk_q  [DEPTH];
  logic [31:0]   tg_q  [DEPTH];

  logic [AW-1:0] head;
  logic [AW-1:0] tail;

  logic          push;
  logic          pop;
  logic          miss;
  logic [31:0]   h_pc;
  logic          h_taken;
  logic [31:0]   h_target;
  logic [31:0]   fix_pc;

  assign pred_ready = (count != CW'(DEPTH));
  assign push       = pred_valid && pred_ready;
  assign pop        = res_valid && (count != '0);

  assign h_pc     = pc_q[head];
  assign h_taken  = tk_q[head];
  assign h_target = tg_q[head];

  // A taken branch to the wrong target is as wrong as a wrong direction.
  assign miss = pop && ((res_taken != h_taken) ||
                        (res_taken && (res_target != h_target)));

  assign fix_pc = res_taken ? res_target : h_pc + 32'd4;

  // Storage carries no reset; occupancy alone defines which slots are live.
  always_ff @(posedge clk) begin
    if (push && !flush && !miss) begin
      pc_q[tail] <= pred_pc;
      tk_q[tail] <= pred_taken;
      tg_q[tail] <= pred_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush || miss) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      update_en    <= 1'b0;
      mispredict   <= 1'b0;
      update_pc    <= '0;
      actual_taken <= 1'b0;
      redirect_pc  <= '0;
    end else begin
      update_en  <= pop && !flush;
      mispredict <= miss && !flush;
      if (pop && !flush) begin
        update_pc    <= h_pc;
        actual_taken <= res_taken;
        redirect_pc  <= fix_pc;
      end
    end
  end

`ifdef BR_RESOLVER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (!flush) begin
      if (pop && stat_branches != '1)
        stat_branches <= stat_branches + 32'd1;
      if (miss && stat_mispredicts != '1)
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule
